dual_port_bus_arbiter: RTL and testbench

- Two-master to one-slave bus arbiter between the CPU and the single shared system bus.
- Port A is the instruction-fetch master and is read-only.
- Port B is the data master and does reads and writes.
- The block grants the bus to one port at a time, forwards address, direction and write data to the bus, returns read data, and completes each transaction with a one-cycle ready pulse. The address decoder and slaves (ROM, RAM, peripherals) sit downstream of o_bus_*.

---
 rtl/dual_port_bus_arbiter.sv | 160 ++++++++++++++++
 tb/tb_dual_port_bus_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dual_port_bus_arbiter.sv
// Round-robin arbiter: instruction port A (read-only) and data port B share one system bus.
// Grant registers one cycle after a request; one-cycle ready pulse after slave ready; waits for the slave unless TIMEOUT > 0.
module dual_port_bus_arbiter #(
  parameter int TIMEOUT = 0
) (
  input  logic        i_clock,
  input  logic        i_reset,
  output logic        o_bus_rw,
  output logic        o_bus_request,
  input  logic        i_bus_ready,
  output logic [31:0] o_bus_address,
  input  logic [31:0] i_bus_rdata,
  output logic [31:0] o_bus_wdata,
  input  logic        i_pa_request,
  output logic        o_pa_ready,
  input  logic [31:0] i_pa_address,
  output logic [31:0] o_pa_rdata,
  input  logic        i_pb_rw,
  input  logic        i_pb_request,
  output logic        o_pb_ready,
  input  logic [31:0] i_pb_address,
  output logic [31:0] o_pb_rdata,
  input  logic [31:0] i_pb_wdata
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BUSY_A,
    S_BUSY_B,
    S_ACK_A,
    S_ACK_B
  } state_t;

  state_t        r_state, w_state;
  logic          r_last_b, w_last_b;
  logic [CW-1:0] r_cnt, w_cnt;
  logic          r_bus_rw, w_bus_rw;
  logic          r_bus_request, w_bus_request;
  logic [31:0]   r_bus_address, w_bus_address;
  logic [31:0]   r_bus_wdata, w_bus_wdata;
  logic          r_pa_ready, w_pa_ready;
  logic [31:0]   r_pa_rdata, w_pa_rdata;
  logic          r_pb_ready, w_pb_ready;
  logic [31:0]   r_pb_rdata, w_pb_rdata;

  logic w_pick_b;
  logic w_timeout;
  logic w_done;

  // B wins when alone or when A was served most recently.
  assign w_pick_b  = i_pb_request & (~i_pa_request | ~r_last_b);
  assign w_timeout = (TIMEOUT != 0) && (r_cnt == CW'(TIMEOUT));
  assign w_done    = i_bus_ready | w_timeout;

  always_comb begin
    w_state       = r_state;
    w_last_b      = r_last_b;
    w_cnt         = r_cnt;
    w_bus_rw      = r_bus_rw;
    w_bus_request = r_bus_request;
    w_bus_address = r_bus_address;
    w_bus_wdata   = r_bus_wdata;
    w_pa_ready    = 1'b0;
    w_pa_rdata    = r_pa_rdata;
    w_pb_ready    = 1'b0;
    w_pb_rdata    = r_pb_rdata;
    case (r_state)
      S_IDLE: begin
        if (w_pick_b) begin
          w_state       = S_BUSY_B;
          w_last_b      = 1'b1;
          w_cnt         = '0;
          w_bus_request = 1'b1;
          w_bus_rw      = i_pb_rw;
          w_bus_address = i_pb_address;
          w_bus_wdata   = i_pb_wdata;
        end else if (i_pa_request) begin
          w_state       = S_BUSY_A;
          w_last_b      = 1'b0;
          w_cnt         = '0;
          w_bus_request = 1'b1;
          w_bus_rw      = 1'b0;
          w_bus_address = i_pa_address;
          w_bus_wdata   = '0;
        end
      end
      S_BUSY_A: begin
        if (w_done) begin
          w_state       = S_ACK_A;
          w_bus_request = 1'b0;
          w_bus_rw      = 1'b0;
          w_pa_ready    = 1'b1;
          w_pa_rdata    = i_bus_ready ? i_bus_rdata : '0;
        end else if (TIMEOUT != 0) begin
          w_cnt = r_cnt + CW'(1);
        end
      end
      S_BUSY_B: begin
        if (w_done) begin
          w_state       = S_ACK_B;
          w_bus_request = 1'b0;
          w_bus_rw      = 1'b0;
          w_pb_ready    = 1'b1;
          // A write completion leaves the last read result visible.
          if (!r_bus_rw) begin
            w_pb_rdata = i_bus_ready ? i_bus_rdata : '0;
          end
        end else if (TIMEOUT != 0) begin
          w_cnt = r_cnt + CW'(1);
        end
      end
      S_ACK_A, S_ACK_B: begin
        w_state = S_IDLE;
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_last_b      <= 1'b0;
      r_cnt         <= '0;
      r_bus_rw      <= 1'b0;
      r_bus_request <= 1'b0;
      r_bus_address <= '0;
      r_bus_wdata   <= '0;
      r_pa_ready    <= 1'b0;
      r_pa_rdata    <= '0;
      r_pb_ready    <= 1'b0;
      r_pb_rdata    <= '0;
    end else begin
      r_state       <= w_state;
      r_last_b      <= w_last_b;
      r_cnt         <= w_cnt;
      r_bus_rw      <= w_bus_rw;
      r_bus_request <= w_bus_request;
      r_bus_address <= w_bus_address;
      r_bus_wdata   <= w_bus_wdata;
      r_pa_ready    <= w_pa_ready;
      r_pa_rdata    <= w_pa_rdata;
      r_pb_ready    <= w_pb_ready;
      r_pb_rdata    <= w_pb_rdata;
    end
  end

  assign o_bus_rw      = r_bus_rw;
  assign o_bus_request = r_bus_request;
  assign o_bus_address = r_bus_address;
  assign o_bus_wdata   = r_bus_wdata;
  assign o_pa_ready    = r_pa_ready;
  assign o_pa_rdata    = r_pa_rdata;
  assign o_pb_ready    = r_pb_ready;
  assign o_pb_rdata    = r_pb_rdata;

endmodule

// File: tb/tb_dual_port_bus_arbiter.sv
// Bench for dual_port_bus_arbiter: directed scenarios followed by random masters/slave against a transaction-level model.
module tb_dual_port_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bus_rw, bus_req, bus_rdy;
  logic [31:0] bus_addr, bus_rdata, bus_wdata;
  logic        pa_req, pa_rdy;
  logic [31:0] pa_addr, pa_rdata;
  logic        pb_rw, pb_req, pb_rdy;
  logic [31:0] pb_addr, pb_rdata, pb_wdata;

  logic        nt_rst = 1'b1;
  logic        nt_req = 1'b0;
  logic        nt_bus_rw, nt_bus_req, nt_pa_rdy, nt_pb_rdy;
  logic [31:0] nt_bus_addr, nt_bus_wdata, nt_pa_rdata, nt_pb_rdata;

  always #5 clk = ~clk;

  dual_port_bus_arbiter #(.TIMEOUT(16)) u_dut (
    .i_clock(clk), .i_reset(rst),
    .o_bus_rw(bus_rw), .o_bus_request(bus_req), .i_bus_ready(bus_rdy),
    .o_bus_address(bus_addr), .i_bus_rdata(bus_rdata), .o_bus_wdata(bus_wdata),
    .i_pa_request(pa_req), .o_pa_ready(pa_rdy), .i_pa_address(pa_addr), .o_pa_rdata(pa_rdata),
    .i_pb_rw(pb_rw), .i_pb_request(pb_req), .o_pb_ready(pb_rdy), .i_pb_address(pb_addr),
    .o_pb_rdata(pb_rdata), .i_pb_wdata(pb_wdata)
  );

  // Second instance without timeout, parked on an address that never answers.
  dual_port_bus_arbiter #(.TIMEOUT(0)) u_nt (
    .i_clock(clk), .i_reset(nt_rst),
    .o_bus_rw(nt_bus_rw), .o_bus_request(nt_bus_req), .i_bus_ready(1'b0),
    .o_bus_address(nt_bus_addr), .i_bus_rdata(32'h0), .o_bus_wdata(nt_bus_wdata),
    .i_pa_request(nt_req), .o_pa_ready(nt_pa_rdy), .i_pa_address(32'h6000_0000), .o_pa_rdata(nt_pa_rdata),
    .i_pb_rw(1'b0), .i_pb_request(1'b0), .o_pb_ready(nt_pb_rdy), .i_pb_address(32'h0),
    .o_pb_rdata(nt_pb_rdata), .i_pb_wdata(32'h0)
  );

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int nt_pulses = 0;
  int nt_start = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (nt_pa_rdy) nt_pulses <= nt_pulses + 1;
  end

  // Reference-model state for the random phase
  bit          m_last_b, a_pend, b_pend, b_rw, cur_rw, prev_req;
  int          cur, low_run, sl_cnt, grants, dones;
  logic [31:0] a_addr, b_addr, b_wdata, cur_addr, cur_wd, exp_pa, exp_pb;
  logic [31:0] mem [logic [31:0]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic any_out();
    return bus_req | bus_rw | (|bus_addr) | (|bus_wdata) | pa_rdy | pb_rdy | (|pa_rdata) | (|pb_rdata);
  endfunction

  task automatic do_reset();
    rst = 1'b1; pa_req = 1'b0; pb_req = 1'b0; bus_rdy = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outputs_zero", any_out(), 0);
    rst = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (bus_req !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk(tag, bus_req, 1);
  endtask

  task automatic step(input bit allow_new);
    bit          win_b;
    logic [31:0] rd;
    if (bus_req && !prev_req) begin
      win_b = pb_req && (!pa_req || !m_last_b);
      chk("rnd_grant_had_request", pa_req | pb_req, 1);
      chk("rnd_idle_gap", low_run >= 2, 1);
      chk("rnd_bus_addr", bus_addr, win_b ? b_addr : a_addr);
      chk("rnd_bus_rw", bus_rw, win_b ? b_rw : 1'b0);
      chk("rnd_bus_wdata", bus_wdata, win_b ? b_wdata : 32'h0);
      cur      = win_b ? 2 : 1;
      m_last_b = win_b;
      cur_rw   = win_b ? b_rw : 1'b0;
      cur_addr = win_b ? b_addr : a_addr;
      cur_wd   = b_wdata;
      sl_cnt   = $urandom_range(0, 3);
      grants++;
    end
    if (pa_rdy) begin
      chk("rnd_pa_owner", cur, 1);
      chk("rnd_pa_rdata", pa_rdata, exp_pa);
      cur = 0; dones++; a_pend = 0; pa_req = 1'b0;
    end
    if (pb_rdy) begin
      chk("rnd_pb_owner", cur, 2);
      chk("rnd_pb_rdata", pb_rdata, exp_pb);
      cur = 0; dones++; b_pend = 0; pb_req = 1'b0;
    end
    low_run  = bus_req ? 0 : low_run + 1;
    prev_req = bus_req;
    if (bus_rdy) begin
      bus_rdy = 1'b0;
    end else if (bus_req && cur != 0) begin
      if (sl_cnt == 0) begin
        bus_rdy = 1'b1;
        if (cur_rw) begin
          mem[cur_addr] = cur_wd;
          bus_rdata = $urandom;
        end else begin
          rd = mem.exists(cur_addr) ? mem[cur_addr] : ~cur_addr;
          bus_rdata = rd;
          if (cur == 1) exp_pa = rd;
          else exp_pb = rd;
        end
      end else begin
        sl_cnt--;
      end
    end
    if (allow_new && !a_pend && $urandom_range(0, 2) == 0) begin
      a_pend = 1; a_addr = 32'($urandom_range(0, 7)) << 2;
      pa_addr = a_addr; pa_req = 1'b1;
    end
    if (allow_new && !b_pend && $urandom_range(0, 2) == 0) begin
      b_pend = 1; b_addr = 32'($urandom_range(0, 7)) << 2;
      b_rw = 1'($urandom_range(0, 1)); b_wdata = $urandom;
      pb_addr = b_addr; pb_rw = b_rw; pb_wdata = b_wdata; pb_req = 1'b1;
    end
  endtask

  initial begin
    int k;
    pa_req = 0; pa_addr = 0; pb_req = 0; pb_rw = 0; pb_addr = 0; pb_wdata = 0;
    bus_rdy = 0; bus_rdata = 0;
    do_reset();
    nt_rst = 1'b0; nt_req = 1'b1; nt_start = cyc;

    // A read, slave answers two cycles after the request appears
    pa_addr = 32'h0000_0100; pa_req = 1'b1;
    @(negedge clk);
    chk("t1_bus_req", bus_req, 1);
    chk("t1_bus_addr", bus_addr, 32'h100);
    chk("t1_bus_rw", bus_rw, 0);
    @(negedge clk);
    chk("t1_req_held", bus_req, 1);
    bus_rdata = 32'hDEAD_BEEF; bus_rdy = 1'b1;
    @(negedge clk);
    bus_rdy = 1'b0;
    chk("t1_pa_ready", pa_rdy, 1);
    chk("t1_pa_rdata", pa_rdata, 32'hDEAD_BEEF);
    chk("t1_req_dropped", bus_req, 0);
    pa_req = 1'b0;
    @(negedge clk);
    chk("t1_single_pulse", pa_rdy, 0);

    // B write; then A immediately re-requests to observe the idle gap
    pb_rw = 1'b1; pb_addr = 32'h0001_0004; pb_wdata = 32'h1234_5678; pb_req = 1'b1;
    @(negedge clk);
    chk("t2_bus_req", bus_req, 1);
    chk("t2_bus_rw", bus_rw, 1);
    chk("t2_bus_addr", bus_addr, 32'h0001_0004);
    chk("t2_bus_wdata", bus_wdata, 32'h1234_5678);
    bus_rdy = 1'b1; bus_rdata = 32'hFFFF_0000;
    @(negedge clk);
    bus_rdy = 1'b0;
    chk("t2_pb_ready", pb_rdy, 1);
    chk("t2_pb_rdata_kept", pb_rdata, 0);
    chk("t2_gap1", bus_req, 0);
    chk("t2_rw_cleared", bus_rw, 0);
    pb_req = 1'b0; pb_rw = 1'b0; pa_addr = 32'h200; pa_req = 1'b1;
    @(negedge clk);
    chk("t2_single_pulse", pb_rdy, 0);
    chk("t2_gap2", bus_req, 0);
    @(negedge clk);
    chk("t2_next_grant", bus_req, 1);
    chk("t2_next_addr", bus_addr, 32'h200);
    bus_rdy = 1'b1; bus_rdata = 32'h0BAD_F00D;
    @(negedge clk);
    bus_rdy = 1'b0; pa_req = 1'b0;
    chk("t2_pa_rdata", pa_rdata, 32'h0BAD_F00D);
    chk("t2_pb_rdata_hold", pb_rdata, 0);
    @(negedge clk);

    // B arrives while A is being served
    pa_addr = 32'h300; pa_req = 1'b1;
    @(negedge clk);
    pb_addr = 32'h400; pb_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_addr_stable", bus_addr, 32'h300);
      chk("t4_pb_not_ready", pb_rdy, 0);
    end
    bus_rdy = 1'b1; bus_rdata = 32'h3333_3333;
    @(negedge clk);
    bus_rdy = 1'b0; pa_req = 1'b0;
    chk("t4_pa_ready", pa_rdy, 1);
    @(negedge clk);
    chk("t4_idle_gap", bus_req, 0);
    @(negedge clk);
    chk("t4_b_granted", bus_addr, 32'h400);
    bus_rdy = 1'b1; bus_rdata = 32'h4444_4444;
    @(negedge clk);
    bus_rdy = 1'b0; pb_req = 1'b0;
    chk("t4_pb_rdata", pb_rdata, 32'h4444_4444);
    @(negedge clk);

    // Persistent tie: winners alternate B, A, B, A starting from reset
    do_reset();
    pa_addr = 32'hA000; pb_addr = 32'hB000; pb_rw = 1'b0; pa_req = 1'b1; pb_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_req("t3_grant");
      chk("t3_winner", bus_addr, (i % 2 == 0) ? 32'hB000 : 32'hA000);
      bus_rdy = 1'b1; bus_rdata = 32'h100 + 32'(i);
      @(negedge clk);
      bus_rdy = 1'b0;
      chk("t3_pa_ready", pa_rdy, (i % 2 == 1) ? 1 : 0);
      chk("t3_pb_ready", pb_rdy, (i % 2 == 0) ? 1 : 0);
      @(negedge clk);
      chk("t3_no_second_pulse", pa_rdy | pb_rdy, 0);
    end
    pa_req = 1'b0; pb_req = 1'b0;
    @(negedge clk);

    // Timeout on an unmapped address
    pa_addr = 32'h6000_0000; pa_req = 1'b1;
    wait_req("t5_grant");
    k = 1;
    while (!pa_rdy && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("t5_pa_ready", pa_rdy, 1);
    chk("t5_latency_17_18", (k - 1 >= 17) && (k - 1 <= 18), 1);
    chk("t5_rdata_zero", pa_rdata, 0);
    chk("t5_req_dropped", bus_req, 0);
    pa_req = 1'b0;
    @(negedge clk);

    // Reset in the middle of a B transaction
    pb_rw = 1'b0; pb_addr = 32'h500; pb_req = 1'b1;
    wait_req("t6_grant");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_outputs_zero", any_out(), 0);
    rst = 1'b0; pb_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("t6_no_pulse", pb_rdy | bus_req, 0);
    end
    pa_addr = 32'h700; pa_req = 1'b1;
    wait_req("t6_new_grant");
    chk("t6_new_addr", bus_addr, 32'h700);
    bus_rdy = 1'b1; bus_rdata = 32'h77;
    @(negedge clk);
    bus_rdy = 1'b0; pa_req = 1'b0;
    chk("t6_new_ready", pa_rdy, 1);
    chk("t6_new_rdata", pa_rdata, 32'h77);
    @(negedge clk);

    // Random traffic against the transaction-level model
    do_reset();
    m_last_b = 0; a_pend = 0; b_pend = 0; cur = 0; low_run = 2; prev_req = 0;
    sl_cnt = 0; grants = 0; dones = 0; exp_pa = 0; exp_pb = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      step(c < 2700);
    end
    for (int c = 0; c < 100 && (a_pend || b_pend || cur != 0); c++) begin
      @(negedge clk);
      step(1'b0);
    end
    chk("rnd_drained", {a_pend, b_pend, cur != 0}, 0);
    chk("rnd_grants_eq_dones", grants, dones);
    chk("rnd_enough_traffic", grants >= 100, 1);

    // TIMEOUT=0 instance must still be waiting after 1000+ cycles
    while (cyc - nt_start < 1000) @(negedge clk);
    chk("t5_nt_still_pending", nt_bus_req, 1);
    chk("t5_nt_no_ready", nt_pulses, 0);
    chk("t5_nt_addr", nt_bus_addr, 32'h6000_0000);
    chk("t5_nt_rw", nt_bus_rw, 0);
    chk("t5_nt_wdata", nt_bus_wdata, 0);
    chk("t5_nt_rdata", nt_pa_rdata | nt_pb_rdata, 0);
    chk("t5_nt_pb_ready", nt_pb_rdy, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
